// File: rtl/simon_player_io.sv
// rtl/simon_player_io.sv - Simon player button front end: synchronise, debounce, press FSM, lamp driver
// Optional feature macro: SIMON_PLAYER_IO_GAMEOVER_BLINK_EN (blink all lamps while gameOver is high)
module simon_player_io #(
    parameter int DEBOUNCE = 3,
    parameter int ECHO     = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       simonTurn,
    input  logic [1:0] simonNum,
    input  logic       simonPressed,
    input  logic       gameOver,
    output logic [1:0] playerNum,
    output logic       playerPressed,
    output logic       multiPress,
    output logic [3:0] led
);
    typedef enum logic [1:0] {LOCKED = 2'd0, ARMED = 2'd1, HELD = 2'd2} state_e;

    state_e          state_q, state_d;
    logic [3:0]      sync1_q, sync2_q, deb_q, deb_d;
    logic [3:0][3:0] cnt_q, cnt_d;
    logic            boot_q, rdy_q, rdy_d;
    logic [5:0]      echo_q, echo_d;
    logic [1:0]      num_q, num_d;
    logic            pressed_q, pressed_d, multi_q, multi_d;
    logic [3:0]      led_q, led_d;
    logic            block, single;
`ifdef SIMON_PLAYER_IO_GAMEOVER_BLINK_EN
    logic [3:0]      blink_cnt_q, blink_cnt_d;
    logic            blink_on_q, blink_on_d;
`endif

    function automatic logic [1:0] encode(input logic [3:0] v);
        case (v)
            4'b0010: encode = 2'd1;
            4'b0100: encode = 2'd2;
            4'b1000: encode = 2'd3;
            default: encode = 2'd0;
        endcase
    endfunction

    assign block  = simonTurn | gameOver;
    assign single = (deb_q != 4'd0) && ((deb_q & (deb_q - 4'd1)) == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            cnt_q     <= '0;
            boot_q    <= 1'b0;
            rdy_q     <= 1'b0;
            state_q   <= LOCKED;
            echo_q    <= '0;
            num_q     <= '0;
            pressed_q <= 1'b0;
            multi_q   <= 1'b0;
            led_q     <= '0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            boot_q    <= 1'b1;
            rdy_q     <= rdy_d;
            state_q   <= state_d;
            echo_q    <= echo_d;
            num_q     <= num_d;
            pressed_q <= pressed_d;
            multi_q   <= multi_d;
            led_q     <= led_d;
        end
    end

`ifdef SIMON_PLAYER_IO_GAMEOVER_BLINK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`endif

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == 4'(DEBOUNCE - 1)) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end else begin
                cnt_d[i] = 4'd0;
            end
        end
    end

    // A button still held through reset must drain out of the pipeline before arming.
    assign rdy_d = rdy_q | (boot_q && sync1_q == 4'd0 && sync2_q == 4'd0 && deb_q == 4'd0);

    always_comb begin
        state_d = state_q;
        if (block) begin
            state_d = LOCKED;
        end else begin
            case (state_q)
                LOCKED:  if (rdy_q && deb_q == 4'd0) state_d = ARMED;
                ARMED:   if (deb_q != 4'd0) state_d = HELD;
                HELD:    if (deb_q == 4'd0) state_d = ARMED;
                default: state_d = LOCKED;
            endcase
        end
    end

    always_comb begin
        pressed_d = 1'b0;
        multi_d   = 1'b0;
        num_d     = num_q;
        if (!block && state_q == ARMED && deb_q != 4'd0) begin
            if (single) begin
                pressed_d = 1'b1;
                num_d     = encode(deb_q);
            end else begin
                multi_d = 1'b1;
            end
        end
    end

    always_comb begin
        echo_d = echo_q;
        if (block)                echo_d = 6'd0;
        else if (pressed_d)       echo_d = 6'(ECHO);
        else if (echo_q != 6'd0)  echo_d = echo_q - 6'd1;
    end

    always_comb begin
        led_d = 4'b0000;
`ifdef SIMON_PLAYER_IO_GAMEOVER_BLINK_EN
        blink_cnt_d = 4'd0;
        blink_on_d  = 1'b1;
`endif
        if (gameOver) begin
`ifdef SIMON_PLAYER_IO_GAMEOVER_BLINK_EN
            led_d = blink_on_q ? 4'b1111 : 4'b0000;
            if (blink_cnt_q == 4'd14) begin
                blink_cnt_d = 4'd0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 4'd1;
                blink_on_d  = blink_on_q;
            end
`else
            led_d = 4'b0000;
`endif
        end else if (simonTurn) begin
            if (simonPressed) led_d = 4'b0001 << simonNum;
        end else if (echo_q != 6'd0) begin
            led_d = 4'b0001 << num_q;
        end
    end

    assign playerNum     = num_q;
    assign playerPressed = pressed_q;
    assign multiPress    = multi_q;
    assign led           = led_q;
endmodule
